// File: rtl/audio_stream_sequencer.sv
// Moves one sample at a time from the RX FIFO through the external processing block into the TX FIFO.
// The result written is always aligned to its own input sample; supports bypass and bounded stall/drop.
module audio_stream_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned PROC_LATENCY = 2,
  parameter int unsigned STALL_LIMIT  = 64,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    bypass,
  input  logic                    adcfifo_empty,
  output logic                    adcfifo_read,
  input  logic [DATA_WIDTH-1:0]   adcfifo_readdata,
  output logic [SAMPLE_WIDTH-1:0] proc_in,
  input  logic [SAMPLE_WIDTH-1:0] proc_out,
  input  logic                    dacfifo_full,
  output logic                    dacfifo_write,
  output logic [DATA_WIDTH-1:0]   dacfifo_writedata,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    sample_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRead    = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StWait    = 3'd3;
  localparam logic [2:0] StWrite   = 3'd4;

  localparam int unsigned StallW = $clog2(STALL_LIMIT + 1);
  localparam logic [3:0]        WaitLast  = 4'(PROC_LATENCY);
  localparam logic [StallW-1:0] StallLast = StallW'(STALL_LIMIT - 1);

  logic [2:0]              state_q, state_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic [SAMPLE_WIDTH-1:0] proc_in_q, proc_in_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   raw_q, raw_d;
  logic                    byp_q, byp_d;
  logic [3:0]              wait_cnt_q, wait_cnt_d;
  logic [StallW-1:0]       stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0]   merged;

  // Upper bits of the raw word pass through untouched around the processed field.
  always_comb begin
    merged                   = raw_q;
    merged[SAMPLE_WIDTH-1:0] = proc_out;
  end

  always_comb begin
    state_d      = state_q;
    read_d       = 1'b0;
    write_d      = 1'b0;
    proc_in_d    = proc_in_q;
    wdata_d      = wdata_q;
    raw_d        = raw_q;
    byp_d        = byp_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    sample_cnt_d = sample_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      StIdle: begin
        if (enable && !adcfifo_empty) begin
          read_d  = 1'b1;
          state_d = StRead;
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
        raw_d      = adcfifo_readdata;
        proc_in_d  = adcfifo_readdata[SAMPLE_WIDTH-1:0];
        byp_d      = bypass;
        wait_cnt_d = '0;
        state_d    = StWait;
      end
      StWait: begin
        if (wait_cnt_q == WaitLast) begin
          wdata_d     = byp_q ? raw_q : merged;
          stall_cnt_d = '0;
          state_d     = StWrite;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      StWrite: begin
        // A free slot always wins, even on the last permitted stall cycle.
        if (!dacfifo_full) begin
          write_d = 1'b1;
          if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_WIDTH'(1);
          state_d = StIdle;
        end else if (stall_cnt_q == StallLast) begin
          if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
          state_d = StIdle;
        end else begin
          stall_cnt_d = stall_cnt_q + StallW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      proc_in_q    <= '0;
      wdata_q      <= '0;
      raw_q        <= '0;
      byp_q        <= 1'b0;
      wait_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      sample_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      proc_in_q    <= proc_in_d;
      wdata_q      <= wdata_d;
      raw_q        <= raw_d;
      byp_q        <= byp_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign adcfifo_read      = read_q;
  assign dacfifo_write     = write_q;
  assign proc_in           = proc_in_q;
  assign dacfifo_writedata = wdata_q;
  assign busy              = (state_q != StIdle);
  assign sample_count      = sample_cnt_q;
  assign drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_audio_stream_sequencer.sv
// Directed bench for audio_stream_sequencer with an RX FIFO model, a 2-cycle >>1 processing model
// and a TX write monitor. Counters are built 8 bits wide so saturation is reachable quickly.
module tb_audio_stream_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        bypass;
  logic        adcfifo_empty;
  logic        adcfifo_read;
  logic [31:0] adcfifo_readdata = '0;
  logic [15:0] proc_in;
  logic [15:0] proc_out = '0;
  logic [15:0] proc_p1 = '0;
  logic        dacfifo_full;
  logic        dacfifo_write;
  logic [31:0] dacfifo_writedata;
  logic        busy;
  logic [7:0]  sample_count;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  audio_stream_sequencer #(
    .DATA_WIDTH  (32),
    .SAMPLE_WIDTH(16),
    .PROC_LATENCY(2),
    .STALL_LIMIT (64),
    .CNT_WIDTH   (8)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .enable           (enable),
    .bypass           (bypass),
    .adcfifo_empty    (adcfifo_empty),
    .adcfifo_read     (adcfifo_read),
    .adcfifo_readdata (adcfifo_readdata),
    .proc_in          (proc_in),
    .proc_out         (proc_out),
    .dacfifo_full     (dacfifo_full),
    .dacfifo_write    (dacfifo_write),
    .dacfifo_writedata(dacfifo_writedata),
    .busy             (busy),
    .sample_count     (sample_count),
    .drop_count       (drop_count)
  );

  // RX FIFO model: pushed advanced by the stimulus, popped by the read strobe.
  logic [31:0] rx_mem [0:511];
  int pushed = 0;
  int popped = 0;
  assign adcfifo_empty = (pushed == popped);

  always @(posedge clk) begin
    if (adcfifo_read) begin
      adcfifo_readdata <= rx_mem[popped[8:0]];
      popped           <= popped + 1;
    end
  end

  // Processing model: input >> 1, two cycles of latency.
  always @(posedge clk) begin
    proc_p1  <= proc_in >> 1;
    proc_out <= proc_p1;
  end

  int rd_pulses = 0;
  int tx_writes = 0;
  always @(posedge clk) begin
    if (adcfifo_read) rd_pulses <= rd_pulses + 1;
    if (dacfifo_write) tx_writes <= tx_writes + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] w);
    rx_mem[pushed[8:0]] = w;
    pushed = pushed + 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int rd_base;
  int tx_base;

  initial begin
    reset_n      = 1'b0;
    enable       = 1'b0;
    bypass       = 1'b0;
    dacfifo_full = 1'b0;
    repeat (3) tick();
    check("rst_read", 32'(adcfifo_read), 32'd0);
    check("rst_write", 32'(dacfifo_write), 32'd0);
    check("rst_proc_in", 32'(proc_in), 32'd0);
    check("rst_wdata", dacfifo_writedata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_scnt", 32'(sample_count), 32'd0);
    check("rst_dcnt", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    tick();

    // Bypass sample: read pulse, write 6 cycles later with the raw word.
    push(32'h0000_1234);
    bypass = 1'b1;
    enable = 1'b1;
    tick();
    check("t1_read", 32'(adcfifo_read), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_read_once", 32'(adcfifo_read), 32'd0);
    repeat (4) tick();
    check("t1_no_early_write", 32'(dacfifo_write), 32'd0);
    tick();
    check("t1_write", 32'(dacfifo_write), 32'd1);
    check("t1_wdata", dacfifo_writedata, 32'h0000_1234);
    check("t1_scnt", 32'(sample_count), 32'd1);
    tick();
    check("t1_write_once", 32'(dacfifo_write), 32'd0);
    check("t1_wdata_hold", dacfifo_writedata, 32'h0000_1234);
    check("t1_reads", 32'(rd_pulses), 32'd1);

    // Processed sample: proc_in stable through WAIT, low field replaced.
    bypass = 1'b0;
    push(32'hABCD_0100);
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c >= 3 && c <= 6) check("t2_proc_in", 32'(proc_in), 32'h0000_0100);
    end
    check("t2_write", 32'(dacfifo_write), 32'd1);
    check("t2_wdata", dacfifo_writedata, 32'hABCD_0080);
    check("t2_scnt", 32'(sample_count), 32'd2);
    tick();
    check("t2_writes", 32'(tx_writes), 32'd2);

    // Full for 10 WRITE cycles, then free: write with unchanged data, no drop.
    dacfifo_full = 1'b1;
    push(32'h0000_5554);
    repeat (16) tick();
    check("t3_stall_no_write", 32'(tx_writes), 32'd2);
    check("t3_stall_busy", 32'(busy), 32'd1);
    check("t3_stall_wdata", dacfifo_writedata, 32'h0000_2AAA);
    dacfifo_full = 1'b0;
    tick();
    check("t3_write", 32'(dacfifo_write), 32'd1);
    check("t3_wdata", dacfifo_writedata, 32'h0000_2AAA);
    check("t3_scnt", 32'(sample_count), 32'd3);
    check("t3_dcnt", 32'(drop_count), 32'd0);
    tick();

    // Full held: drop after exactly 64 stall cycles, then the next sample is read.
    dacfifo_full = 1'b1;
    push(32'h0000_0010);
    push(32'h0000_0020);
    repeat (69) tick();
    check("t4_pre_drop_dcnt", 32'(drop_count), 32'd0);
    check("t4_pre_drop_busy", 32'(busy), 32'd1);
    tick();
    check("t4_dcnt", 32'(drop_count), 32'd1);
    check("t4_idle", 32'(busy), 32'd0);
    check("t4_no_write", 32'(tx_writes), 32'd3);
    tick();
    check("t4_next_read", 32'(adcfifo_read), 32'd1);
    dacfifo_full = 1'b0;
    repeat (6) tick();
    check("t4_write", 32'(dacfifo_write), 32'd1);
    check("t4_wdata", dacfifo_writedata, 32'h0000_0010);
    check("t4_scnt", 32'(sample_count), 32'd4);
    tick();

    // Disabled: no reads. Enable dropped during WAIT: current sample still completes.
    enable = 1'b0;
    push(32'h0000_0077);
    push(32'h0000_0099);
    rd_base = rd_pulses;
    repeat (20) tick();
    check("t5_no_read", 32'(rd_pulses - rd_base), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    tick();
    check("t5_read", 32'(adcfifo_read), 32'd1);
    repeat (2) tick();
    enable = 1'b0;
    repeat (4) tick();
    check("t5_write", 32'(dacfifo_write), 32'd1);
    check("t5_wdata", dacfifo_writedata, 32'h0000_003B);
    repeat (20) tick();
    check("t5_one_read", 32'(rd_pulses - rd_base), 32'd1);
    check("t5_scnt", 32'(sample_count), 32'd5);

    // Reset during WAIT: everything clears at once, no write follows.
    enable = 1'b1;
    repeat (3) tick();
    check("t6_proc_in", 32'(proc_in), 32'h0000_0099);
    tx_base = tx_writes;
    reset_n = 1'b0;
    #1;
    check("t6_proc_in_rst", 32'(proc_in), 32'd0);
    check("t6_busy_rst", 32'(busy), 32'd0);
    check("t6_scnt_rst", 32'(sample_count), 32'd0);
    check("t6_dcnt_rst", 32'(drop_count), 32'd0);
    check("t6_wdata_rst", dacfifo_writedata, 32'd0);
    repeat (10) tick();
    check("t6_no_write", 32'(tx_writes - tx_base), 32'd0);
    enable  = 1'b0;
    reset_n = 1'b1;
    tick();

    // Saturation of the 8-bit sample counter.
    bypass = 1'b1;
    for (int i = 0; i < 260; i++) push(32'(i));
    tx_base = tx_writes;
    enable  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (tx_writes - tx_base >= 260) break;
    end
    check("t7_writes", 32'(tx_writes - tx_base), 32'd260);
    check("t7_scnt_sat", 32'(sample_count), 32'h0000_00FF);
    check("t7_dcnt", 32'(drop_count), 32'd0);
    check("t7_last_wdata", dacfifo_writedata, 32'd259);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
